// File: rtl/ble_tx.sv
// ble_tx: serial packet transmitter. Payload bytes are buffered in a
// first-word-fall-through FIFO; a packet is preamble, access address,
// whitened payload and whitened CRC24, one bit per en strobe, LSB first.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for start; FIFO may be filled
// PRE   | 8 preamble bits (0xAA or 0x55 depending on aa[0])
// AA    | 32 access address bits, bit 0 first
// PAY   | len payload bytes popped from FIFO, whitened, CRC'd
// CRC   | 24 CRC bits, MSB first, whitened
// END   | drop tx_valid, pulse done, release busy
module ble_tx #(
    parameter int          FIFO_ADDR_W = 6,
    parameter logic [23:0] CRC_INIT    = 24'h555555,
    parameter int          CH_IDX_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [7:0]          data_in,
    output logic                full,
    output logic                empty,
    input  logic                start,
    input  logic [31:0]         aa,
    input  logic [CH_IDX_W-1:0] ch_idx,
    input  logic [7:0]          len,
    output logic                busy,
    output logic                done,
    output logic                underrun,
    output logic                tx,
    output logic                tx_valid
);

    localparam int          DEPTH    = 1 << FIFO_ADDR_W;
    localparam logic [23:0] CRC_POLY = 24'h00065B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_AA,
        S_PAY,
        S_CRC,
        S_END
    } state_t;

    state_t               state;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_ADDR_W:0] wr_ptr;
    logic [FIFO_ADDR_W:0] rd_ptr;
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic [7:0]           head;

    // sh holds {aa, preamble} at start; during PAY its low 7 bits hold the
    // rest of the byte that was just popped.
    logic [39:0]          sh;
    logic [4:0]           bit_cnt;
    logic [7:0]           byte_left;
    logic [6:0]           w;
    logic [6:0]           w_next;
    logic [23:0]          crc;
    logic [23:0]          crc_shift;
    logic [23:0]          crc_pay_next;
    logic                 byte_first;
    logic                 pay_bit;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_ADDR_W] != rd_ptr[FIFO_ADDR_W]) &&
                     (wr_ptr[FIFO_ADDR_W-1:0] == rd_ptr[FIFO_ADDR_W-1:0]);
    assign fifo_wr = wr_en && !full;
    assign head    = mem[rd_ptr[FIFO_ADDR_W-1:0]];

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr[FIFO_ADDR_W-1:0]] <= data_in;
        end
    end

    // FIFO pointers; only rst empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Bit 0 of each payload byte comes straight from the FIFO head on the pop cycle.
    always_comb begin
        byte_first   = (state == S_PAY) && (bit_cnt == 5'd7);
        pay_bit      = byte_first ? head[0] : sh[0];
        fifo_rd      = en && byte_first && !empty;
        w_next       = {w[0], w[6:4], w[3] ^ w[0], w[2:1]};
        crc_shift    = {crc[22:0], 1'b0};
        crc_pay_next = crc_shift ^ ({24{crc[23] ^ pay_bit}} & CRC_POLY);
    end

    // Packet sequencer; everything except start acceptance advances on en only.
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            underrun  <= 1'b0;
            tx        <= 1'b0;
            tx_valid  <= 1'b0;
            done      <= 1'b0;
            sh        <= '0;
            bit_cnt   <= '0;
            byte_left <= '0;
            w         <= '0;
            crc       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_PRE;
                        busy      <= 1'b1;
                        underrun  <= 1'b0;
                        sh        <= {aa, (aa[0] ? 8'h55 : 8'hAA)};
                        w         <= {1'b1, ch_idx[5:0]};
                        crc       <= CRC_INIT;
                        byte_left <= len;
                        bit_cnt   <= 5'd7;
                    end
                end
                S_PRE: begin
                    if (en) begin
                        tx       <= sh[0];
                        tx_valid <= 1'b1;
                        sh       <= sh >> 1;
                        if (bit_cnt == 5'd0) begin
                            state   <= S_AA;
                            bit_cnt <= 5'd31;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                S_AA: begin
                    if (en) begin
                        tx <= sh[0];
                        sh <= sh >> 1;
                        if (bit_cnt == 5'd0) begin
                            if (byte_left == 8'd0) begin
                                state   <= S_CRC;
                                bit_cnt <= 5'd23;
                            end else begin
                                state   <= S_PAY;
                                bit_cnt <= 5'd7;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                S_PAY: begin
                    if (en) begin
                        if (byte_first && empty) begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            underrun <= 1'b1;
                            tx       <= 1'b0;
                            tx_valid <= 1'b0;
                        end else begin
                            tx  <= pay_bit ^ w[0];
                            w   <= w_next;
                            crc <= crc_pay_next;
                            sh  <= byte_first ? {33'd0, head[7:1]} : (sh >> 1);
                            if (bit_cnt == 5'd0) begin
                                byte_left <= byte_left - 1'b1;
                                if (byte_left == 8'd1) begin
                                    state   <= S_CRC;
                                    bit_cnt <= 5'd23;
                                end else begin
                                    bit_cnt <= 5'd7;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                end
                S_CRC: begin
                    if (en) begin
                        tx  <= crc[23] ^ w[0];
                        w   <= w_next;
                        crc <= crc_shift;
                        if (bit_cnt == 5'd0) begin
                            state <= S_END;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                S_END: begin
                    if (en) begin
                        tx       <= 1'b0;
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ble_tx.sv
// tb_ble_tx: randomized bench for ble_tx with a packet-level reference model.
module tb_ble_tx;

    localparam int          AW    = 6;
    localparam int          DEPTH = 64;
    localparam logic [23:0] SEED  = 24'h555555;

    logic        clk = 1'b0;
    logic        rst;
    logic        en = 1'b1;
    logic        wr_en;
    logic [7:0]  data_in;
    logic        full;
    logic        empty;
    logic        start;
    logic [31:0] aa;
    logic [5:0]  ch_idx;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        underrun;
    logic        tx;
    logic        tx_valid;

    ble_tx #(.FIFO_ADDR_W(AW), .CRC_INIT(SEED)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .data_in(data_in),
        .full(full), .empty(empty), .start(start), .aa(aa), .ch_idx(ch_idx),
        .len(len), .busy(busy), .done(done), .underrun(underrun),
        .tx(tx), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int en_mode = 0;

    // Reference model: the whole expected packet is built as a list of items
    // when start is accepted (0/1 = bit, 2 = normal end, 3 = underrun abort).
    bit         model_on = 1'b0;
    bit         active   = 1'b0;
    logic [7:0] mq[$];
    int         pk[$];
    bit         exp_tx, exp_txv, exp_busy, exp_done, exp_und;
    bit         cap[$];
    int         done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] wh_step(input logic [6:0] wv);
        return {wv[0], wv[6:4], wv[3] ^ wv[0], wv[2:1]};
    endfunction

    function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
        logic fb;
        fb = c[23] ^ b;
        c  = c << 1;
        if (fb) c = c ^ 24'h00065B;
        return c;
    endfunction

    function automatic void build(input logic [31:0] a, input logic [5:0] ch, input int n);
        logic [7:0]  pre;
        logic [6:0]  wv;
        logic [23:0] c;
        logic [7:0]  d;
        pre = a[0] ? 8'h55 : 8'hAA;
        wv  = {1'b1, ch};
        c   = SEED;
        pk.delete();
        for (int i = 0; i < 8; i++) pk.push_back(int'(pre[i]));
        for (int i = 0; i < 32; i++) pk.push_back(int'(a[i]));
        for (int k = 0; k < n; k++) begin
            if (mq.size() == 0) begin
                pk.push_back(3);
                return;
            end
            d = mq.pop_front();
            for (int i = 0; i < 8; i++) begin
                pk.push_back(int'(d[i] ^ wv[0]));
                c  = crc_step(c, d[i]);
                wv = wh_step(wv);
            end
        end
        for (int i = 23; i >= 0; i--) begin
            pk.push_back(int'(c[i] ^ wv[0]));
            wv = wh_step(wv);
        end
        pk.push_back(2);
    endfunction

    always @(negedge clk) begin
        case (en_mode)
            0:       en = 1'b1;
            1:       en = ~en;
            default: en = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Model update at each active edge, then compare DUT outputs 1ns later.
    always @(posedge clk) begin
        bit         e, s, r, w;
        logic [7:0] d;
        int         it;
        r = rst; e = en; s = start; w = wr_en; d = data_in;
        exp_done = 1'b0;
        if (r) begin
            model_on = 1'b1;
            active   = 1'b0;
            mq.delete();
            pk.delete();
            exp_tx = 0; exp_txv = 0; exp_busy = 0; exp_und = 0;
        end else if (model_on) begin
            if (active) begin
                if (e) begin
                    it = pk.pop_front();
                    if (it < 2) begin
                        exp_tx  = it[0];
                        exp_txv = 1'b1;
                    end else begin
                        exp_tx   = 1'b0;
                        exp_txv  = 1'b0;
                        exp_busy = 1'b0;
                        active   = 1'b0;
                        if (it == 2) exp_done = 1'b1;
                        else         exp_und  = 1'b1;
                    end
                end
            end else if (s) begin
                build(aa, ch_idx, int'(len));
                active   = 1'b1;
                exp_busy = 1'b1;
                exp_und  = 1'b0;
            end
            if (w && mq.size() < DEPTH) mq.push_back(d);
        end
        #1;
        if (model_on) begin
            if (e && tx_valid === 1'b1) cap.push_back(tx);
            if (done === 1'b1) done_cnt++;
            chk("tx", tx, exp_tx);
            chk("tx_valid", tx_valid, exp_txv);
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("underrun", underrun, exp_und);
            if (!active) begin
                chk("empty", empty, mq.size() == 0);
                chk("full", full, mq.size() == DEPTH);
            end
        end
    end

    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        data_in = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [5:0] ch, input logic [7:0] l);
        aa = a; ch_idx = ch; len = l;
        cap.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (active && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_timeout"}, active, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0, k, l;
        logic [7:0]  lp;
        logic [31:0] la;
        logic [6:0]  wv;
        logic [7:0]  got;

        rst = 1'b1; wr_en = 1'b0; start = 1'b0; data_in = '0;
        aa = '0; ch_idx = '0; len = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);

        chk("pin_whiten", wh_step(7'b1100101), 7'b1110110);
        chk("pin_crc_fb1", crc_step(24'h000000, 1'b1), 24'h00065B);
        chk("pin_crc_nofb", crc_step(24'h555555, 1'b0), 24'hAAAAAA);
        chk("pin_crc_msb", crc_step(24'h800000, 1'b0), 24'h00065B);

        // header only
        en_mode = 0;
        d0 = done_cnt;
        send(32'h8E89BED6, 6'd37, 8'd0);
        wait_idle("hdr");
        chk("hdr_bits", cap.size(), 64);
        lp = 8'hAA;
        la = 32'h8E89BED6;
        for (int i = 0; i < 8; i++) chk("hdr_pre", cap[i], lp[i]);
        for (int i = 0; i < 32; i++) chk("hdr_aa", cap[8 + i], la[i]);
        chk("hdr_done_cnt", done_cnt - d0, 1);

        // loopback-style check of 4 bytes, en every other cycle
        en_mode = 1;
        for (int i = 1; i <= 4; i++) wr(8'(i));
        la = $urandom;
        lp = 8'($urandom_range(0, 39));
        send(la, lp[5:0], 8'd4);
        wait_idle("lb");
        chk("lb_bits", cap.size(), 64 + 32);
        wv = {1'b1, lp[5:0]};
        for (int b = 0; b < 4; b++) begin
            got = '0;
            for (int i = 0; i < 8; i++) begin
                got[i] = cap[40 + 8 * b + i] ^ wv[0];
                wv = wh_step(wv);
            end
            chk("lb_byte", got, b + 1);
        end

        // underrun: 2 bytes for a 3-byte packet
        en_mode = 2;
        d0 = done_cnt;
        wr(8'h5A); wr(8'hC3);
        send($urandom, 6'($urandom), 8'd3);
        wait_idle("und");
        repeat (2) @(negedge clk);
        chk("und_bits", cap.size(), 8 + 32 + 16);
        chk("und_flag", underrun, 1'b1);
        chk("und_no_done", done_cnt - d0, 0);
        chk("und_busy", busy, 1'b0);
        chk("und_empty", empty, 1'b1);

        // FIFO boundaries: 65 writes, then a 64-byte packet with a stray start
        en_mode = 0;
        for (int i = 0; i < 64; i++) wr(8'($urandom));
        chk("fifo_full64", full, 1'b1);
        wr(8'hEE);
        chk("fifo_full65", full, 1'b1);
        en_mode = 2;
        send($urandom, 6'($urandom), 8'd64);
        repeat (200) @(negedge clk);
        aa = $urandom; len = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("big");
        chk("big_bits", cap.size(), 64 + 8 * 64);
        chk("big_empty", empty, 1'b1);

        // reset during access address
        en_mode = 0;
        for (int i = 0; i < 3; i++) wr(8'($urandom));
        send(32'h8E89BED6, 6'd5, 8'd3);
        k = 0;
        while (cap.size() < 28 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reach", cap.size(), 28);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_tx_valid", tx_valid, 1'b0);
        chk("mid_empty", empty, 1'b1);
        send(32'h8E89BED6, 6'd5, 8'd0);
        wait_idle("mid_new");
        chk("mid_new_bits", cap.size(), 64);
        chk("mid_new_pre0", cap[0], 1'b0);

        // back-to-back packets
        en_mode = 2;
        for (int i = 0; i < 5; i++) wr(8'($urandom));
        send($urandom, 6'($urandom), 8'd2);
        wait_idle("b2b_a");
        chk("b2b_done", done, 1'b1);
        send($urandom, 6'($urandom), 8'd3);
        wait_idle("b2b_b");
        chk("b2b_bits", cap.size(), 64 + 24);

        // random packets, some short of bytes
        for (int p = 0; p < 8; p++) begin
            l = $urandom_range(0, 12);
            k = (p % 3 == 2 && l > 0) ? l - 1 : l;
            for (int i = 0; i < k; i++) wr(8'($urandom));
            en_mode = $urandom_range(0, 2);
            send($urandom, 6'($urandom), 8'(l));
            wait_idle("rnd");
            chk("rnd_bits", cap.size(), (k < l) ? 40 + 8 * k : 64 + 8 * l);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
